add_subtract_scan: RTL and testbench



---
 rtl/add_subtract_scan.sv | 171 +++++++++++++++++
 tb/tb_add_subtract_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/add_subtract_scan.sv
// Bit-serial W-bit add/subtract, W+2 cycles start-to-done, shown as hex magnitude on a scanned DIGITS-digit 7-segment display.
// start is ignored while busy; optional leading-zero blanking enabled by defining ADDSUB_LZB_EN.
module add_subtract_scan #(
    parameter int W        = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      A,
    input  logic [W-1:0]      B,
    input  logic              O,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [6:0]        S,
    output logic              DP,
    output logic [DIGITS-1:0] AN
);
    localparam int RW = 4 * DIGITS;
    localparam int CW = $clog2(W);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            carry_q, carry_d, op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   res_q, res_d;
    logic            sign_q, sign_d, busy_q, busy_d, done_q, done_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic            sbit;
    logic [W-1:0]    neg;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sbit    = 1'b0;
        neg     = (~sum_q) + W'(1);
        case (state_q)
            IDLE: if (start) begin
                a_d     = A;
                b_d     = O ? ~B : B;
                carry_d = O;
                op_d    = O;
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                // operands shift right so bit 0 is always the current bit; sum fills from the MSB
                sbit    = a_q[0] ^ b_q[0] ^ carry_q;
                carry_d = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
                sum_d   = {sbit, sum_q[W-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1))
                    state_d = FIX;
            end
            FIX: begin
                if (!op_q) begin
                    res_d  = RW'({carry_q, sum_q});
                    sign_d = 1'b0;
                end else if (carry_q) begin
                    res_d  = RW'(sum_q);
                    sign_d = 1'b0;
                end else begin
                    res_d  = RW'(neg);
                    sign_d = 1'b1;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        dig_d   = dig_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            dig_d   = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            presc_q <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            dig_q   <= dig_d;
        end
    end

    logic [RW-1:0] shifted;
    logic [3:0]    nib;
    logic [6:0]    glyph;

    always_comb begin
        shifted = res_q >> {dig_q, 2'b00};
        nib     = shifted[3:0];
        case (nib)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
`ifdef ADDSUB_LZB_EN
        // a digit is blank when it and every digit above it are zero
        if (dig_q != '0 && shifted == '0)
            glyph = 7'b0000000;
`endif
    end

    assign S    = glyph;
    assign DP   = sign_q && (dig_q == DW'(DIGITS - 1));
    assign AN   = ~(DIGITS'(1) << dig_q);
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_add_subtract_scan.sv
// Randomized bench for add_subtract_scan against an arithmetic model of result, sign and scan position.
module tb_add_subtract_scan;
    localparam int W        = 8;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic       O = 1'b0, start = 1'b0;
    logic       busy, done, DP;
    logic [6:0] S;
    logic [2:0] AN;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic [6:0] glyph_tab [16];

    add_subtract_scan #(.W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .O(O), .start(start),
        .busy(busy), .done(done), .S(S), .DP(DP), .AN(AN)
    );

    always #5 clk = ~clk;

    // rising edges since the last reset release; selects the digit being scanned
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    function automatic void model(input int a, input int b, input bit o,
                                  output int res, output bit sign);
        if (!o)          begin res = a + b; sign = 0; end
        else if (a >= b) begin res = a - b; sign = 0; end
        else             begin res = b - a; sign = 1; end
    endfunction

    function automatic logic [6:0] exp_seg(input int res, input int d);
`ifdef ADDSUB_LZB_EN
        if (d > 0 && (res >> (4 * d)) == 0) return 7'b0000000;
`endif
        return glyph_tab[(res >> (4 * d)) & 15];
    endfunction

    task automatic check_display(input int res, input bit sign, input string tag);
        int d;
        logic [2:0] exp_an;
        logic [2:0] one;
        one = 3'b001;
        for (int i = 0; i < SCAN_DIV * DIGITS; i++) begin
            @(negedge clk);
            d = (cyc / SCAN_DIV) % DIGITS;
            exp_an = ~(one << d);
            n_checks++;
            if (AN !== exp_an) begin
                n_fail++;
                $display("FAIL %s AN: got %b expected %b", tag, AN, exp_an);
            end
            n_checks++;
            if (S !== exp_seg(res, d)) begin
                n_fail++;
                $display("FAIL %s S digit%0d: got %b expected %b", tag, d, S, exp_seg(res, d));
            end
            n_checks++;
            if (DP !== (sign && d == DIGITS - 1)) begin
                n_fail++;
                $display("FAIL %s DP digit%0d: got %b expected %b", tag, d, DP, sign && d == DIGITS - 1);
            end
        end
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge of the done cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic o, input string tag);
        A = a; B = b; O = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); O = 1'($urandom);
        for (int i = 1; i <= W + 1; i++) begin
            if (i > 1) @(negedge clk);
            n_checks++;
            if ({busy, done} !== 2'b10) begin
                n_fail++;
                $display("FAIL %s busy/done cycle %0d: got %b%b expected 10", tag, i, busy, done);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s done pulse: got busy=%b done=%b expected busy=0 done=1", tag, busy, done);
        end
    endtask

    task automatic test_op(input int a, input int b, input bit o, input string tag);
        int res; bit sign;
        model(a, b, o, res, sign);
        run_op(8'(a), 8'(b), o, tag);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done width: got %b expected 0", tag, done);
        end
        check_display(res, sign, tag);
    endtask

    task automatic test_reset();
        logic [2:0] one;
        one = 3'b001;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({AN, S, DP, busy, done} !== {3'b110, 7'b0111111, 3'b000}) begin
            n_fail++;
            $display("FAIL reset outputs: got AN=%b S=%b DP=%b busy=%b done=%b expected 110 0111111 0 0 0",
                     AN, S, DP, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            n_checks++;
            if (AN !== ~(one << ((cyc / SCAN_DIV) % DIGITS))) begin
                n_fail++;
                $display("FAIL reset scan step %0d: got AN=%b", i, AN);
            end
        end
        check_display(0, 0, "reset_disp");
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        A = 8'h02; B = 8'h06; O = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) begin A = 8'hFF; O = 1'b0; start = 1'b1; end
            if (i == 4) start = 1'b0;
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignored_start done count: got %0d expected 1", dones);
        end
        check_display(4, 1, "ignored_start");
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        A = 8'h02; B = 8'h06; O = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset abort: got busy=%b done=%b expected 0 0", busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL mid_reset done count: got %0d expected 0", dones);
        end
        check_display(0, 0, "mid_reset");
    endtask

    task automatic test_back_to_back();
        int res; bit sign;
        run_op(8'h10, 8'h20, 1'b0, "b2b_first");
        model(8'h81, 8'hC3, 1'b1, res, sign);
        run_op(8'h81, 8'hC3, 1'b1, "b2b_second");
        @(negedge clk);
        check_display(res, sign, "b2b");
    endtask

    task automatic test_random();
        int a, b; bit o;
        for (int n = 0; n < 12; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            o = 1'($urandom);
            test_op(a, b, o, "random");
        end
    endtask

    initial begin
        glyph_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        test_reset();
        test_op(8'h03, 8'h04, 0, "add_3_4");
        test_op(8'h03, 8'h04, 1, "sub_3_4");
        test_op(8'hFF, 8'hFF, 0, "add_ff_ff");
        test_op(8'h05, 8'h05, 1, "sub_5_5");
        test_op(8'h00, 8'hFF, 1, "sub_0_ff");
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
